// File: rtl/led_rate_detector_pkg.sv
// Shared types and helpers for the LED blink-rate detector.
// Rate codes follow the blinker's {switch_1,switch_2} encoding.
package led_rate_detector_pkg;

  typedef enum logic [1:0] {
    RATE_100 = 2'b00,
    RATE_50  = 2'b01,
    RATE_10  = 2'b10,
    RATE_1   = 2'b11
  } rate_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic  hit;
    rate_t rate;
  } cls_t;

  localparam int LOCK_W = 4;

  function automatic int win_lo(input int c, input int sh);
    return c - (c >> sh);
  endfunction

  function automatic int win_hi(input int c, input int sh);
    return c + (c >> sh);
  endfunction

  function automatic bit win_overlap(input int a, input int b,
                                     input int sh);
    return !((win_hi(a, sh) < win_lo(b, sh)) ||
             (win_hi(b, sh) < win_lo(a, sh)));
  endfunction

endpackage

// File: rtl/led_rate_detector_edge_sync.sv
// Two-flop synchronizer for the LED input plus a registered
// either-polarity edge strobe.
module led_edge_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_led,
  output logic o_edge
);

  logic [1:0] sync_q;
  logic       last_q;
  logic [1:0] fill_q;
  logic       edge_q;
  logic       primed;

  // Strobes stay masked until the pipe holds real samples, so a
  // high LED at reset release is not mistaken for an edge.
  assign primed = (fill_q == 2'd3);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= 2'b00;
      last_q <= 1'b0;
      fill_q <= 2'd0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_led};
      last_q <= sync_q[1];
      if (!primed) begin
        fill_q <= fill_q + 2'd1;
      end
      edge_q <= primed & (sync_q[1] ^ last_q);
    end
  end

  assign o_edge = edge_q;

endmodule

// File: rtl/led_rate_detector.sv
// Measures LED half-periods and locks onto one of four blink
// rates once enough consecutive matching measurements are seen.
module led_rate_detector
  import led_rate_detector_pkg::*;
#(
  parameter int c100      = 125000,
  parameter int c50       = 250000,
  parameter int c10       = 1250000,
  parameter int c1        = 12500000,
  parameter int tol_shift = 3,
  parameter int lock_n    = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_led,
  output logic [1:0]                 o_sel,
  output logic                       o_locked,
  output logic                       o_meas_valid,
  output logic [$clog2(2*c1+1)-1:0]  o_period,
  output logic                       o_stalled
);

  localparam int W = $clog2(2*c1+1);

  localparam logic [W-1:0] TMO    = W'(2*c1);
  localparam logic [W-1:0] TMO_M1 = W'(2*c1-1);

  localparam logic [W-1:0] LO_100 = W'(win_lo(c100, tol_shift));
  localparam logic [W-1:0] HI_100 = W'(win_hi(c100, tol_shift));
  localparam logic [W-1:0] LO_50  = W'(win_lo(c50, tol_shift));
  localparam logic [W-1:0] HI_50  = W'(win_hi(c50, tol_shift));
  localparam logic [W-1:0] LO_10  = W'(win_lo(c10, tol_shift));
  localparam logic [W-1:0] HI_10  = W'(win_hi(c10, tol_shift));
  localparam logic [W-1:0] LO_1   = W'(win_lo(c1, tol_shift));
  localparam logic [W-1:0] HI_1   = W'(win_hi(c1, tol_shift));

  localparam logic [LOCK_W-1:0] LOCK_N = LOCK_W'(lock_n);

  if (win_overlap(c100, c50, tol_shift) ||
      win_overlap(c100, c10, tol_shift) ||
      win_overlap(c100, c1, tol_shift)  ||
      win_overlap(c50, c10, tol_shift)  ||
      win_overlap(c50, c1, tol_shift)   ||
      win_overlap(c10, c1, tol_shift)) begin : g_win_chk
    $error("led_rate_detector: acceptance windows overlap");
  end

  if (lock_n < 2 || lock_n > 15) begin : g_lock_chk
    $error("led_rate_detector: lock_n out of range 2..15");
  end

  logic                edge_s;
  logic [W-1:0]        cnt_q;
  logic                tmo_hit;
  logic                in_100, in_50, in_10, in_1;
  cls_t                cls;

  state_t              state_q, state_d;
  logic [LOCK_W-1:0]   match_q, match_d;
  rate_t               cand_q, cand_d;
  rate_t               sel_q, sel_d;
  logic                locked_q, locked_d;
  logic [W-1:0]        period_q, period_d;
  logic                mv_q, mv_d;
  logic                stalled_q, stalled_d;

  led_edge_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_led   (i_led),
    .o_edge  (edge_s)
  );

  // Half-period counter; reloads to 1 so a toggle every N clocks reads N.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (!i_enable) begin
      cnt_q <= '0;
    end else if (edge_s) begin
      cnt_q <= W'(1);
    end else if (cnt_q != TMO) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_hit = i_enable & ~edge_s & (cnt_q == TMO_M1);

  assign in_100 = (cnt_q >= LO_100) && (cnt_q <= HI_100);
  assign in_50  = (cnt_q >= LO_50)  && (cnt_q <= HI_50);
  assign in_10  = (cnt_q >= LO_10)  && (cnt_q <= HI_10);
  assign in_1   = (cnt_q >= LO_1)   && (cnt_q <= HI_1);

  always_comb begin
    cls = '{hit: 1'b0, rate: RATE_100};
    unique case (1'b1)
      in_100:  cls = '{hit: 1'b1, rate: RATE_100};
      in_50:   cls = '{hit: 1'b1, rate: RATE_50};
      in_10:   cls = '{hit: 1'b1, rate: RATE_10};
      in_1:    cls = '{hit: 1'b1, rate: RATE_1};
      default: cls = '{hit: 1'b0, rate: RATE_100};
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      match_q   <= '0;
      cand_q    <= RATE_100;
      sel_q     <= RATE_100;
      locked_q  <= 1'b0;
      period_q  <= '0;
      mv_q      <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      cand_q    <= cand_d;
      sel_q     <= sel_d;
      locked_q  <= locked_d;
      period_q  <= period_d;
      mv_q      <= mv_d;
      stalled_q <= stalled_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    cand_d    = cand_q;
    sel_d     = sel_q;
    locked_d  = locked_q;
    period_d  = period_q;
    mv_d      = 1'b0;
    stalled_d = stalled_q;

    if (!i_enable) begin
      state_d   = ST_IDLE;
      match_d   = '0;
      cand_d    = RATE_100;
      sel_d     = RATE_100;
      locked_d  = 1'b0;
      period_d  = '0;
      stalled_d = 1'b0;
    end else if (edge_s) begin
      // An edge always wins over a coincident timeout.
      stalled_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_MEASURE;
          match_d = '0;
        end
        ST_MEASURE: begin
          period_d = cnt_q;
          mv_d     = 1'b1;
          if (cls.hit && match_q != '0 && cls.rate == cand_q) begin
            match_d = match_q + 1'b1;
          end else begin
            cand_d  = cls.rate;
            match_d = {{(LOCK_W-1){1'b0}}, cls.hit};
          end
          if (match_d == LOCK_N) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            sel_d    = cand_d;
          end
        end
        ST_LOCKED: begin
          period_d = cnt_q;
          mv_d     = 1'b1;
          if (!cls.hit || cls.rate != sel_q) begin
            state_d  = ST_MEASURE;
            locked_d = 1'b0;
            cand_d   = cls.rate;
            match_d  = {{(LOCK_W-1){1'b0}}, cls.hit};
          end
        end
        default: begin
          state_d = ST_IDLE;
          match_d = '0;
        end
      endcase
    end else if (tmo_hit) begin
      stalled_d = 1'b1;
      locked_d  = 1'b0;
      state_d   = ST_IDLE;
      match_d   = '0;
    end
  end

  assign o_sel        = sel_q;
  assign o_locked     = locked_q;
  assign o_meas_valid = mv_q;
  assign o_period     = period_q;
  assign o_stalled    = stalled_q;

endmodule

// File: tb/tb_led_rate_detector.sv
// Randomized bench for led_rate_detector with a half-period
// level reference model of the lock rules.
module tb_led_rate_detector;

  localparam int C100  = 10;
  localparam int C50   = 20;
  localparam int C10   = 50;
  localparam int C1    = 100;
  localparam int TOL   = 3;
  localparam int LOCKN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       led = 1'b0;
  logic [1:0] sel;
  logic       locked;
  logic       mv;
  logic [7:0] period;
  logic       stalled;

  led_rate_detector #(
    .c100      (C100),
    .c50       (C50),
    .c10       (C10),
    .c1        (C1),
    .tol_shift (TOL),
    .lock_n    (LOCKN)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_led        (led),
    .o_sel        (sel),
    .o_locked     (locked),
    .o_meas_valid (mv),
    .o_period     (period),
    .o_stalled    (stalled)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_cyc = 0;
  int exp_q[$];
  int crate[4] = '{C100, C50, C10, C1};
  int bad[6]   = '{5, 8, 12, 30, 70, 150};

  bit m_locked = 0;
  int m_sel    = 0;
  int m_cand   = -1;
  int m_cnt    = 0;
  bit fresh    = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int classify(input int p);
    for (int i = 0; i < 4; i++) begin
      if (p >= crate[i] - (crate[i] >> TOL) &&
          p <= crate[i] + (crate[i] >> TOL))
        return i;
    end
    return -1;
  endfunction

  function automatic void model_step(input int p);
    int k;
    k = classify(p);
    if (!m_locked) begin
      if (k >= 0 && m_cnt > 0 && k == m_cand) begin
        m_cnt++;
      end else begin
        m_cand = k;
        m_cnt  = (k >= 0) ? 1 : 0;
      end
      if (m_cnt == LOCKN) begin
        m_locked = 1;
        m_sel    = k;
      end
    end else if (k < 0 || k != m_sel) begin
      m_locked = 0;
      m_cand   = k;
      m_cnt    = (k >= 0) ? 1 : 0;
    end
  endfunction

  function automatic void model_clear(input bit keep_sel);
    m_locked = 0;
    m_cnt    = 0;
    m_cand   = -1;
    fresh    = 1;
    if (!keep_sel) m_sel = 0;
  endfunction

  // Toggle the LED n clocks after the previous toggle.
  task automatic toggle_one(input int n);
    while (cyc - last_cyc < n) begin
      @(posedge clk);
      #1;
    end
    led = ~led;
    if (fresh) fresh = 0;
    else exp_q.push_back(cyc - last_cyc);
    last_cyc = cyc;
  endtask

  task automatic toggle_run(input int n, input int cnt);
    repeat (cnt) toggle_one(n);
  endtask

  always @(negedge clk) begin : mon
    int p;
    if (mv) begin
      chk("meas_pending", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        model_step(p);
        chk("period", int'(period), p);
        chk("locked", int'(locked), int'(m_locked));
        chk("sel", int'(sel), m_sel);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, len, n, t;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_mv", int'(mv), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_stalled", int'(stalled), 0);
    rst = 1'b0;
    model_clear(0);
    last_cyc = cyc;
    repeat (5) @(posedge clk);
    #1;

    toggle_run(C100, 6);
    repeat (6) @(posedge clk);
    #1;
    chk("lock_100", int'(locked), 1);
    chk("sel_100", int'(sel), 0);

    toggle_run(C10, 5);
    repeat (6) @(posedge clk);
    #1;
    chk("relock_10", int'(locked), 1);
    chk("sel_10", int'(sel), 2);

    repeat (14) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 en = 1'b1;
    model_clear(0);
    @(negedge clk);
    chk("en_locked", int'(locked), 0);
    chk("en_period", int'(period), 0);
    chk("en_sel", int'(sel), 0);
    toggle_run(C10, 5);

    repeat (3) begin
      toggle_one(9);
      toggle_one(11);
    end
    repeat (4) begin
      toggle_one(8);
      toggle_one(12);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("nolock_8_12", int'(locked), 0);

    toggle_run(C50, 5);
    repeat (202) @(posedge clk);
    #1;
    chk("stall_early", int'(stalled), 0);
    chk("stall_pre_lock", int'(locked), 1);
    @(posedge clk);
    #1;
    chk("stall_set", int'(stalled), 1);
    chk("stall_unlock", int'(locked), 0);
    chk("stall_sel_hold", int'(sel), 1);
    model_clear(1);
    toggle_one(C100);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold", int'(stalled), 1);
    @(posedge clk);
    #1;
    chk("stall_clear", int'(stalled), 0);

    toggle_run(C100, 3);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", int'(sel), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_mv", int'(mv), 0);
    chk("arst_period", int'(period), 0);
    chk("arst_stalled", int'(stalled), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear(0);
    repeat (5) @(posedge clk);
    #1;
    toggle_run(C100, 4);
    repeat (6) @(posedge clk);
    #1;
    chk("arst_not_yet", int'(locked), 0);
    toggle_run(C100, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("arst_relock", int'(locked), 1);

    repeat (14) begin
      r   = int'($urandom_range(0, 3));
      len = int'($urandom_range(2, 7));
      repeat (len) begin
        if ($urandom_range(0, 7) == 0) begin
          n = bad[$urandom_range(0, 5)];
        end else begin
          t = crate[r] >> TOL;
          n = crate[r] - t + int'($urandom_range(0, 2 * t));
        end
        toggle_one(n);
      end
    end

    repeat (8) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("final_locked", int'(locked), int'(m_locked));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
